// File: rtl/hsk_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin handshake arbiter.
// Optional checkers are enabled with HSK_RR_ARBITER_ASSERT_EN (see hsk_rr_arbiter.sv).
package hsk_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } arb_state_e;

    localparam int MAX_REQ = 16;

    // Pointer moves one past the last winner so that winner gets lowest priority next time.
    function automatic int unsigned rr_next_ptr(input int unsigned w, input int unsigned n);
        return (w + 1 >= n) ? 0 : w + 1;
    endfunction

endpackage

// File: rtl/hsk_rr_arbiter_if.sv
// Handshake bundle between NUM_REQ requesters, the arbiter and the downstream consumer.
// The arbiter uses the slave modport; the surrounding environment uses master.
interface hsk_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [ID_W-1:0]           out_id;
    logic                      out_ready;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/hsk_rr_arbiter_rr_picker.sv
// Combinational round-robin pick: rotate req_valid so ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_picker #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    winner
);
    localparam logic [ID_W:0] NR = (ID_W+1)'(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    logic [ID_W-1:0]    off;
    logic [ID_W:0]      sum;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        logic [ID_W:0] src;
        always_comb begin
            src = (ID_W+1)'(gi) + {1'b0, ptr};
            if (src >= NR) begin
                src = src - NR;
            end
        end
        assign rot[gi] = req_valid[src[ID_W-1:0]];
    end

    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = ID_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NR) begin
            sum = sum - NR;
        end
        winner = sum[ID_W-1:0];
        any    = |req_valid;
    end
endmodule

// File: rtl/hsk_rr_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output stage.
// Define HSK_RR_ARBITER_ASSERT_EN to compile in protocol and fairness assertions.
module hsk_rr_arbiter
    import hsk_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    hsk_rr_arbiter_if.slave  bus
);
    arb_state_e        state_reg;
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic [ID_W-1:0]   out_id_reg;
    logic [ID_W-1:0]   ptr_reg;

    logic              any;
    logic [ID_W-1:0]   winner;
    logic              can_accept;
    logic              accept;
    logic [DATA_W-1:0] win_data;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_valid (bus.req_valid),
        .ptr       (ptr_reg),
        .any       (any),
        .winner    (winner)
    );

    // A FULL stage being drained this cycle can take a new beat with no bubble.
    assign can_accept = (state_reg == IDLE) || bus.out_ready;
    assign accept     = can_accept && any && !rst;
    assign win_data   = bus.req_data[int'(winner)*DATA_W +: DATA_W];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign bus.req_ready[gi] = accept && (winner == ID_W'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_id_reg    <= '0;
            ptr_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg     <= FULL;
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= win_data;
                        out_id_reg    <= winner;
                        ptr_reg       <= ID_W'(rr_next_ptr(32'(winner), NUM_REQ));
                    end
                end
                FULL: begin
                    if (accept) begin
                        out_data_reg  <= win_data;
                        out_id_reg    <= winner;
                        ptr_reg       <= ID_W'(rr_next_ptr(32'(winner), NUM_REQ));
                    end else if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_id    = out_id_reg;

`ifdef HSK_RR_ARBITER_ASSERT_EN
    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        bus.out_valid && !bus.out_ready |=>
            $stable(bus.out_valid) && $stable(bus.out_data) && $stable(bus.out_id));

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.req_ready));

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fair
        // Counts accepts that went elsewhere while this requester kept valid high.
        logic [ID_W:0] wait_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wait_reg <= '0;
            end else if (!bus.req_valid[gi] || bus.req_ready[gi]) begin
                wait_reg <= '0;
            end else if (accept) begin
                wait_reg <= wait_reg + 1'b1;
            end
        end

        a_ready_valid: assert property (@(posedge clk) disable iff (rst)
            bus.req_ready[gi] |-> bus.req_valid[gi]);

        a_fair: assert property (@(posedge clk) disable iff (rst)
            accept && bus.req_valid[gi] && wait_reg >= (ID_W+1)'(NUM_REQ - 1)
                |-> bus.req_ready[gi]);
    end
`else
    // Checkers are left out of this build; behaviour is unchanged.
`endif
endmodule

// File: doc/hsk_rr_arbiter.md
# hsk_rr_arbiter

Round-robin arbiter that shares one valid/ready/data handshake channel among `NUM_REQ` requesters and feeds the downstream handshake consumer. It accepts one winner's beat into a registered output stage and holds that beat stable until the consumer takes it. Back-to-back transfers sustain one beat per clock. It sits directly upstream of the handshake datapath, and the protocol checker is bound to its output channel.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_W`, 8: payload width.
- `ID_W`, `$clog2(NUM_REQ)`: width of the grant index. Derived; not to be overridden.

Ports:
- `clk` input 1: single clock; everything is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input NUM_REQ: per-requester valid.
- `req_data` input NUM_REQ*DATA_W: packed payloads; requester i uses bits [i*DATA_W +: DATA_W].
- `req_ready` output NUM_REQ: per-requester accept strobe; combinational; at most one bit high.
- `out_valid` output 1: registered; a beat is pending downstream.
- `out_data` output DATA_W: registered payload of the pending beat.
- `out_ready` input 1: downstream accept.
- `out_id` output ID_W: registered index of the requester that sourced the pending beat.

## Operation

- States: IDLE (no pending beat) and FULL (`out_valid`=1).
- **Accept condition.**
  - `can_accept` = IDLE, or (FULL and `out_ready`).
  - When `can_accept` is true and any `req_valid` is high, the winner w gets `req_ready[w]`=1 in that cycle.
  - On the next edge: `out_data`<=payload of w, `out_id`<=w, state<=FULL.
- **FULL without `out_ready`.** `out_valid`, `out_data` and `out_id` hold. All `req_ready` are 0.
- **FULL with `out_ready`.**
  - If no request is present: state<=IDLE and `out_valid`<=0.
  - If a request is present: a new winner is accepted in the same cycle. State stays FULL with the new data, with no bubble.
- **Round-robin pick.**
  - Search `req_valid` starting at `ptr` and moving upward, wrapping from NUM_REQ-1 to 0. The first set bit wins.
  - `ptr`<=(w+1) mod NUM_REQ, updated only on an accept.
- **Requester rules.** A requester's `req_valid` may drop without a handshake; the arbiter tolerates this. `req_data` is sampled only in the accept cycle.
- **Single requester.** A single continuously requesting source wins every accept cycle.
- **Reset** (any time, including while FULL):
  - `out_valid`=0, `out_data`=0, `out_id`=0, `ptr`=0, state=IDLE.
  - `req_ready` is forced to all-zero while `rst` is high.
  - A pending beat is discarded.

## Timing

- Latency: the accept cycle (`req_valid`&`req_ready`) is followed by `out_valid`=1 one clock later.
- Throughput: one beat per clock while `out_ready`=1 and requests are present.
- `req_ready` depends combinationally on `req_valid`, `out_ready`, state and `ptr`. There is no combinational path from `req_data` to any output.
- The output channel obeys the team handshake rule: once `out_valid` rises, `out_valid` and `out_data` stay stable until the cycle in which `out_ready` is 1.
- Starvation bound: a requester holding valid is accepted within NUM_REQ accept opportunities.

## Configuration

- Macro: `HSK_RR_ARBITER_ASSERT_EN`.
- **Defined:** concurrent assertions are compiled into the block, all disabled during `rst`:
  - `out_valid && !out_ready` implies `out_valid`, `out_data` and `out_id` are stable on the next cycle.
  - `req_ready` is `$onehot0`.
  - `req_ready[i]` implies `req_valid[i]`.
  - Fairness: a `req_valid[i]` held continuously is accepted within NUM_REQ accepts.
- **Undefined:** no assertion code is compiled, and behaviour is identical.

## Structure

- **Package `hsk_arb_pkg`:**
  - state enum `arb_state_e` {IDLE, FULL};
  - `MAX_REQ` constant (16);
  - function `rr_next_ptr`.
- **Sub-module `rr_picker`** (combinational): rotate-and-priority-encode. It takes `req_valid` and `ptr` and returns `any` and `winner`. The top module holds the FSM, output register and pointer.

## Test plan

- **Reset mid-transfer:** rst=1 while FULL with `out_data`=8'hA5 -> `out_valid`=0, `out_data`=0 and `req_ready`=0 immediately. After release, the first accept goes to requester 0 (`ptr`=0).
- **All four requesting, `out_ready`=1 throughout,** payloads 8'h10/11/12/13 -> consecutive beats with `out_id` 0,1,2,3,0, one per clock, no bubbles.
- **Downstream stall:** requester 2 sends 8'h5A, then `out_ready`=0 for 5 cycles -> `out_valid`, `out_data`=8'h5A and `out_id`=2 stable, all `req_ready`=0. On `out_ready`=1 the beat completes.
- **Wrap-around pick:** last winner 3 (`ptr`=0), requesters 1 and 3 valid -> requester 1 wins. Then with `ptr`=2 and requesters 1 and 3 valid, requester 3 wins.
- **Withdrawn request:** requester 1 raises valid while FULL and stalled, then drops it before `out_ready` -> no accept for 1; the next accept goes to another valid requester.
- **Single requester 0 streaming 8'h01..8'h08 with `out_ready`=1** -> eight beats in eight consecutive cycles, `out_id`=0 each, data in order.
